// File: rtl/rv32i_types.sv
// Shared RV32I type definitions.
//   branch_funct3_t : funct3 encodings for conditional branches (codes 010/011 are unused)
//   bctrl_state_t   : branch_ctrl redirect FSM states
package rv32i_types;

  typedef enum logic [2:0] {
    F3Beq  = 3'b000,
    F3Bne  = 3'b001,
    F3Blt  = 3'b100,
    F3Bge  = 3'b101,
    F3Bltu = 3'b110,
    F3Bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    StRun,
    StRedirect,
    StDrain
  } bctrl_state_t;

  localparam logic [31:0] InstrBytes = 32'd4;

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Funct3-coded branch condition comparator (purely combinational).
//   funct3 : branch condition select
//   a, b   : rs1 / rs2 operands
//   taken  : condition result; unused funct3 codes evaluate to not-taken
module branch_ctrl_cmp
  import rv32i_types::*;
(
  input  branch_funct3_t funct3,
  input  logic [31:0]    a,
  input  logic [31:0]    b,
  output logic           taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3Beq:   taken = (a == b);
      F3Bne:   taken = (a != b);
      F3Blt:   taken = ($signed(a) <  $signed(b));
      F3Bge:   taken = ($signed(a) >= $signed(b));
      F3Bltu:  taken = (a <  b);
      F3Bgeu:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution and fetch-redirect controller in the EXE stage.
// Resolves branches/JAL/JALR, detects mispredictions, drives a held redirect
// request to fetch plus a one-cycle drain flush, trains the BHT and keeps
// saturating branch / mispredict counters. All outputs are registered.
//   clk, rst_n                        : clock, async active-low reset
//   exe_valid, exe_stall              : EXE occupancy and freeze
//   exe_is_br/_jal/_jalr, exe_funct3  : instruction class and branch condition
//   rs1_data, rs2_data, exe_pc, exe_imm : operands
//   pred_taken, pred_target           : fetch-time prediction
//   fetch_ready                       : fetch accepts the redirect
//   redirect_valid, redirect_pc, flush: redirect request and pipeline kill
//   bht_upd_valid/_taken/_pc          : predictor training pulse
//   br_count, mispred_count           : performance counters
module branch_ctrl
  import rv32i_types::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           exe_valid,
  input  logic           exe_stall,
  input  logic           exe_is_br,
  input  logic           exe_is_jal,
  input  logic           exe_is_jalr,
  input  branch_funct3_t exe_funct3,
  input  logic [31:0]    rs1_data,
  input  logic [31:0]    rs2_data,
  input  logic [31:0]    exe_pc,
  input  logic [31:0]    exe_imm,
  input  logic           pred_taken,
  input  logic [31:0]    pred_target,
  input  logic           fetch_ready,
  output logic           redirect_valid,
  output logic [31:0]    redirect_pc,
  output logic           flush,
  output logic           bht_upd_valid,
  output logic           bht_upd_taken,
  output logic [31:0]    bht_upd_pc,
  output logic [31:0]    br_count,
  output logic [31:0]    mispred_count
);

  bctrl_state_t state;

  logic        cond_taken;
  logic        resolve;
  logic        actual_taken;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] correct_pc;
  logic        mispredict;

  branch_ctrl_cmp u_cmp (
    .funct3 (exe_funct3),
    .a      (rs1_data),
    .b      (rs2_data),
    .taken  (cond_taken)
  );

  // Only RUN resolves; anything in EXE during REDIRECT/DRAIN is wrong-path.
  assign resolve = exe_valid && !exe_stall && (state == StRun) &&
                   (exe_is_br || exe_is_jal || exe_is_jalr);

  assign actual_taken = exe_is_br ? cond_taken : (exe_is_jal || exe_is_jalr);
  assign target       = exe_is_jalr ? ((rs1_data + exe_imm) & ~32'd1) : (exe_pc + exe_imm);
  assign seq_pc       = exe_pc + InstrBytes;
  assign correct_pc   = actual_taken ? target : seq_pc;
  // Target mismatch only matters when the instruction is actually taken.
  assign mispredict   = (actual_taken != pred_taken) ||
                        (actual_taken && (target != pred_target));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StRun;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      bht_upd_valid  <= 1'b0;
      bht_upd_taken  <= 1'b0;
      bht_upd_pc     <= '0;
      br_count       <= '0;
      mispred_count  <= '0;
    end else begin
      bht_upd_valid <= resolve && exe_is_br;
      if (resolve && exe_is_br) begin
        bht_upd_taken <= actual_taken;
        bht_upd_pc    <= exe_pc;
      end

      if (resolve && (br_count != '1)) begin
        br_count <= br_count + 32'd1;
      end
      if (resolve && mispredict && (mispred_count != '1)) begin
        mispred_count <= mispred_count + 32'd1;
      end

      case (state)
        StRun: begin
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          if (resolve && mispredict) begin
            state          <= StRedirect;
            redirect_pc    <= correct_pc;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
          end
        end
        StRedirect: begin
          // redirect_pc is held; request stays up until fetch takes it.
          if (fetch_ready) begin
            state          <= StDrain;
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
          end
        end
        StDrain: begin
          state          <= StRun;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
        end
        default: begin
          state          <= StRun;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
  import rv32i_types::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           exe_valid, exe_stall, exe_is_br, exe_is_jal, exe_is_jalr;
  branch_funct3_t exe_funct3;
  logic [31:0]    rs1_data, rs2_data, exe_pc, exe_imm;
  logic           pred_taken;
  logic [31:0]    pred_target;
  logic           fetch_ready;
  logic           redirect_valid, flush;
  logic [31:0]    redirect_pc;
  logic           bht_upd_valid, bht_upd_taken;
  logic [31:0]    bht_upd_pc, br_count, mispred_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mp   = 0;

  branch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exe_valid      (exe_valid),
    .exe_stall      (exe_stall),
    .exe_is_br      (exe_is_br),
    .exe_is_jal     (exe_is_jal),
    .exe_is_jalr    (exe_is_jalr),
    .exe_funct3     (exe_funct3),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .exe_pc         (exe_pc),
    .exe_imm        (exe_imm),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .bht_upd_valid  (bht_upd_valid),
    .bht_upd_taken  (bht_upd_taken),
    .bht_upd_pc     (bht_upd_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model. kind: 0 = conditional branch, 1 = JAL, 2 = JALR.
  function automatic void model(input int kind, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic pt, input logic [31:0] ptg,
                                output logic tk, output logic [31:0] tgt,
                                output logic [31:0] npc, output logic mp);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (kind != 0) tk = 1'b1;
    else if (f3 == 3'd0) tk = (a == b);
    else if (f3 == 3'd1) tk = (a != b);
    else if (f3 == 3'd4) tk = (sa < sb);
    else if (f3 == 3'd5) tk = (sa >= sb);
    else if (f3 == 3'd6) tk = (a < b);
    else if (f3 == 3'd7) tk = (a >= b);
    else tk = 1'b0;
    if (kind == 2) tgt = {a[31:1] + imm[31:1] + {30'd0, a[0] & imm[0]}, 1'b0};
    else tgt = pc + imm;
    npc = tk ? tgt : pc + 32'd4;
    mp  = (tk != pt) || (tk && (tgt != ptg));
  endfunction

  task automatic drive_idle();
    exe_valid = 1'b0; exe_stall = 1'b0;
    exe_is_br = 1'b0; exe_is_jal = 1'b0; exe_is_jalr = 1'b0;
    exe_funct3 = F3Beq;
    rs1_data = '0; rs2_data = '0; exe_pc = '0; exe_imm = '0;
    pred_taken = 1'b0; pred_target = '0;
  endtask

  task automatic drive_garbage();
    int k;
    k = $urandom_range(0, 2);
    exe_valid = 1'b1; exe_stall = 1'b0;
    exe_is_br = (k == 0); exe_is_jal = (k == 1); exe_is_jalr = (k == 2);
    exe_funct3 = branch_funct3_t'(3'($urandom));
    rs1_data = $urandom; rs2_data = $urandom; exe_pc = $urandom; exe_imm = $urandom;
    pred_taken = $urandom_range(0, 1); pred_target = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction from RUN (at #1 after an edge) and walks it through
  // stalls, resolution and, on mispredict, the redirect/drain handshake.
  task automatic run_instr(input string tag, input int kind, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic pt, input logic [31:0] ptg,
                           input int stalls, input int ready_delay);
    logic tk, mp;
    logic [31:0] tgt, npc;
    model(kind, f3, a, b, pc, imm, pt, ptg, tk, tgt, npc, mp);
    exe_valid = 1'b1; exe_stall = (stalls > 0);
    exe_is_br = (kind == 0); exe_is_jal = (kind == 1); exe_is_jalr = (kind == 2);
    exe_funct3 = branch_funct3_t'(f3);
    rs1_data = a; rs2_data = b; exe_pc = pc; exe_imm = imm;
    pred_taken = pt; pred_target = ptg; fetch_ready = 1'b0;
    for (int s = 0; s < stalls; s++) begin
      tick();
      if (s == stalls - 1) exe_stall = 1'b0;
      n_checks++;
      if (br_count !== 32'(exp_br) || bht_upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall: br_count=%0d bht=%b rv=%b, want %0d 0 0", tag,
                 br_count, bht_upd_valid, redirect_valid, exp_br);
      end
    end
    tick();
    drive_idle();
    exp_br++;
    if (mp) exp_mp++;
    n_checks++;
    if (br_count !== 32'(exp_br) || mispred_count !== 32'(exp_mp)) begin
      n_fail++;
      $display("FAIL %s counters: br=%0d mp=%0d, want %0d %0d", tag, br_count,
               mispred_count, exp_br, exp_mp);
    end
    n_checks++;
    if (bht_upd_valid !== (kind == 0) ||
        (kind == 0 && (bht_upd_taken !== tk || bht_upd_pc !== pc))) begin
      n_fail++;
      $display("FAIL %s bht: v=%b t=%b pc=%h, want %b %b %h", tag, bht_upd_valid,
               bht_upd_taken, bht_upd_pc, kind == 0, tk, pc);
    end
    n_checks++;
    if (redirect_valid !== mp || flush !== mp || (mp && redirect_pc !== npc)) begin
      n_fail++;
      $display("FAIL %s redirect: rv=%b fl=%b pc=%h, want %b %b %h", tag, redirect_valid,
               flush, redirect_pc, mp, mp, npc);
    end
    if (mp) begin
      drive_garbage();
      for (int d = 0; d < ready_delay; d++) begin
        tick();
        drive_garbage();
        n_checks++;
        if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== npc ||
            br_count !== 32'(exp_br) || mispred_count !== 32'(exp_mp)) begin
          n_fail++;
          $display("FAIL %s hold: rv=%b fl=%b pc=%h br=%0d mp=%0d, want 1 1 %h %0d %0d",
                   tag, redirect_valid, flush, redirect_pc, br_count, mispred_count,
                   npc, exp_br, exp_mp);
        end
      end
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      drive_garbage();
      n_checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b1 || bht_upd_valid !== 1'b0 ||
          br_count !== 32'(exp_br) || mispred_count !== 32'(exp_mp)) begin
        n_fail++;
        $display("FAIL %s drain: rv=%b fl=%b bht=%b br=%0d mp=%0d", tag, redirect_valid,
                 flush, bht_upd_valid, br_count, mispred_count);
      end
      tick();
      drive_idle();
      n_checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || bht_upd_valid !== 1'b0 ||
          br_count !== 32'(exp_br) || mispred_count !== 32'(exp_mp)) begin
        n_fail++;
        $display("FAIL %s post-drain: rv=%b fl=%b bht=%b br=%0d mp=%0d", tag,
                 redirect_valid, flush, bht_upd_valid, br_count, mispred_count);
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    fetch_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || bht_upd_valid !== 1'b0 ||
        redirect_pc !== 32'd0 || br_count !== 32'd0 || mispred_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: rv=%b fl=%b bht=%b pc=%h br=%0d mp=%0d", redirect_valid,
               flush, bht_upd_valid, redirect_pc, br_count, mispred_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_br = 0;
    exp_mp = 0;
  endtask

  task automatic test_directed();
    run_instr("beq_hit", 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 0, 0);
    run_instr("blt_mis", 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h0, 0, 0);
    run_instr("bltu_hold", 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240,
              0, 3);
    run_instr("jalr_hit", 2, 3'd0, 32'h1003, 32'd0, 32'h500, 32'd0, 1'b1, 32'h1002, 0, 0);
    run_instr("jalr_mis", 2, 3'd0, 32'h1003, 32'd0, 32'h500, 32'd0, 1'b1, 32'h1000, 0, 1);
    run_instr("jal_wrap", 1, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10, 0, 0);
  endtask

  task automatic test_stall_and_noclass();
    run_instr("stall2", 0, 3'd1, 32'd3, 32'd4, 32'h300, 32'h8, 1'b1, 32'h308, 2, 0);
    // Valid instruction with no branch class must not resolve.
    exe_valid = 1'b1; rs1_data = 32'd1; rs2_data = 32'd1;
    tick();
    drive_idle();
    n_checks++;
    if (br_count !== 32'(exp_br) || bht_upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL noclass: br=%0d bht=%b rv=%b, want %0d 0 0", br_count,
               bht_upd_valid, redirect_valid, exp_br);
    end
    run_instr("stall_mis", 0, 3'd5, 32'd1, 32'hFFFF_FFFF, 32'h400, 32'h10, 1'b0, 32'h0, 2, 2);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b0", 1, 3'd0, 32'd0, 32'd0, 32'h600, 32'h40, 1'b1, 32'h640, 0, 0);
    run_instr("b2b1", 0, 3'd7, 32'd9, 32'd2, 32'h640, 32'h10, 1'b1, 32'h650, 0, 0);
    run_instr("b2b2", 0, 3'd2, 32'd9, 32'd2, 32'h650, 32'h10, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_reset_in_redirect();
    run_instr("pre_rst", 0, 3'd0, 32'd1, 32'd1, 32'h700, 32'h20, 1'b1, 32'h720, 0, 0);
    exe_valid = 1'b1; exe_is_br = 1'b1; exe_funct3 = F3Bne;
    rs1_data = 32'd1; rs2_data = 32'd2; exe_pc = 32'h800; exe_imm = 32'h40;
    pred_taken = 1'b0; fetch_ready = 1'b0;
    tick();
    drive_idle();
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h840) begin
      n_fail++;
      $display("FAIL rst_redirect_pre: rv=%b pc=%h, want 1 00000840", redirect_valid,
               redirect_pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || br_count !== 32'd0 ||
        mispred_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_async: rv=%b fl=%b br=%0d mp=%0d, want 0 0 0 0", redirect_valid,
               flush, br_count, mispred_count);
    end
    fetch_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fetch_ready = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: rv=%b fl=%b, want 0 0", redirect_valid, flush);
    end
    run_instr("post_rst", 0, 3'd4, 32'd1, 32'd2, 32'h900, 32'h10, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [2:0] f3;
      logic [31:0] a, b, pc, imm, ptg, tgt, npc;
      logic pt, tk, mp;
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom);
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {1'b1, a[30:0]};
      pc   = {$urandom, 2'b00};
      imm  = ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom))) : $urandom;
      model(kind, f3, a, b, pc, imm, 1'b0, 32'd0, tk, tgt, npc, mp);
      if ($urandom_range(0, 1) == 1) begin
        pt  = tk;
        ptg = tk ? tgt : 32'($urandom);
      end else begin
        pt  = $urandom_range(0, 1);
        ptg = ($urandom_range(0, 1) == 1) ? tgt : 32'($urandom);
      end
      run_instr($sformatf("rnd%0d", i), kind, f3, a, b, pc, imm, pt, ptg,
                $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_and_noclass();
    test_back_to_back();
    test_reset_in_redirect();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
